// File: rtl/rv_pkg.sv
// Shared RISC-V constants and types for the memory stage.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] BUBBLE_INSN_DFLT = 32'd0;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } mem_state_t;

endpackage

// File: rtl/ls_align.sv
// Byte-lane steering for loads and stores: byte enables, store data replication,
// load extraction/extension and misalignment / illegal-funct3 detection.
module ls_align
  import rv_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        fault
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
  end

  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be      = 4'b1111;
    wdata   = rs2;
    ld_data = rdata;
    fault   = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{rs2[7:0]}};
        end
        F3_H: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{rs2[15:0]}};
          fault = addr_lo[0];
        end
        F3_W:    fault = |addr_lo;
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  ld_data = {{24{byte_lane[7]}}, byte_lane};
        F3_BU: ld_data = {24'd0, byte_lane};
        F3_H: begin
          ld_data = {{16{half_lane[15]}}, half_lane};
          fault   = addr_lo[0];
        end
        F3_HU: begin
          ld_data = {16'd0, half_lane};
          fault   = addr_lo[0];
        end
        F3_W:    fault = |addr_lo;
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores over a valid/ready request and
// valid response handshake, stalls upstream while busy, and fills the M/W latch.
//
// state     | meaning
// IDLE      | no access outstanding; request driven combinationally for memory ops
// WAIT_RESP | load accepted, waiting for dmem_resp_valid
module mem_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSN = BUBBLE_INSN_DFLT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_ALU_O,
  input  logic [31:0] i_regfile_B,
  output logic        o_stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata,
  output logic [31:0] o_insn,
  output logic [31:0] o_ALU_O,
  output logic [31:0] o_mem_data,
  output logic        o_mem_fault
);

  mem_state_t  state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;

  logic        is_load, is_store, is_mem, align_fault;
  logic [31:0] ld_data;
  logic        req_valid_c, stall_c;

  assign is_load  = (i_insn[6:0] == OP_LOAD);
  assign is_store = (i_insn[6:0] == OP_STORE);
  assign is_mem   = is_load | is_store;

  ls_align u_ls_align (
    .is_store (is_store),
    .funct3   (i_insn[14:12]),
    .addr_lo  (i_ALU_O[1:0]),
    .rs2      (i_regfile_B),
    .rdata    (dmem_resp_rdata),
    .be       (dmem_req_be),
    .wdata    (dmem_req_wdata),
    .ld_data  (ld_data),
    .fault    (align_fault)
  );

  always_comb begin
    state_d     = state_q;
    insn_d      = BUBBLE_INSN;
    alu_d       = alu_q;
    data_d      = data_q;
    fault_d     = 1'b0;
    req_valid_c = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          insn_d = i_insn;
          alu_d  = i_ALU_O;
          data_d = 32'd0;
        end else if (align_fault) begin
          fault_d = 1'b1;
        end else begin
          req_valid_c = 1'b1;
          if (is_store) begin
            stall_c = !dmem_req_ready;
            if (dmem_req_ready) begin
              insn_d = i_insn;
              alu_d  = i_ALU_O;
              data_d = 32'd0;
            end
          end else begin
            stall_c = 1'b1;
            if (dmem_req_ready) state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        stall_c = !dmem_resp_valid;
        if (dmem_resp_valid) begin
          insn_d  = i_insn;
          alu_d   = i_ALU_O;
          data_d  = ld_data;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // M/W boundary updates on the falling edge of the pipeline clock
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      insn_q  <= BUBBLE_INSN;
      alu_q   <= 32'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign dmem_req_valid = req_valid_c & reset;
  assign o_stall        = stall_c & reset;
  assign dmem_req_we    = is_store;
  assign dmem_req_addr  = {i_ALU_O[31:2], 2'b00};
  assign o_insn         = insn_q;
  assign o_ALU_O        = alu_q;
  assign o_mem_data     = data_q;
  assign o_mem_fault    = fault_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage RISC-V pipeline. Sits directly downstream of the X/M pipeline latch and consumes its insn, ALU result and rs2 value.
- Runs loads and stores against data memory over a valid/ready request and valid response handshake. Stalls the upstream pipeline while an access is outstanding.
- Registers the completed result into the M/W boundary for writeback.

Parameters:
- BUBBLE_INSN, 32'd0, instruction word injected toward writeback when no instruction completes.

Ports:
- clock  in  1  pipeline clock; all state updates on the falling edge
- reset  in  1  asynchronous reset, active-low
- i_insn  in  32  instruction from X/M latch
- i_ALU_O  in  32  ALU result; effective address for loads/stores
- i_regfile_B  in  32  rs2 value; store data
- o_stall  out  1  hold X/M latch and all earlier stages this cycle
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request this cycle
- dmem_req_we  out  1  1 = store, 0 = load
- dmem_req_addr  out  32  word-aligned address, {i_ALU_O[31:2],2'b00}
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_be  out  4  byte enables (stores); 4'b1111 for loads
- dmem_resp_valid  in  1  load data valid
- dmem_resp_rdata  in  32  raw load word
- o_insn  out  32  M/W insn
- o_ALU_O  out  32  M/W ALU result
- o_mem_data  out  32  M/W formatted load data
- o_mem_fault  out  1  registered one-cycle pulse: misaligned or illegal-funct3 access dropped

Behaviour:
- Reset (reset=0, async):
  - state = IDLE; o_insn = BUBBLE_INSN; o_ALU_O = 0; o_mem_data = 0; o_mem_fault = 0.
  - dmem_req_valid and o_stall forced 0 while reset is low.
  - Reset mid-access abandons the access; any later dmem_resp_valid seen in IDLE is ignored.
- Decode:
  - LOAD: opcode 7'b0000011. Legal funct3 = 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - STORE: opcode 7'b0100011. Legal funct3 = 000 SB, 001 SH, 010 SW.
  - Any other opcode is a non-memory instruction.
- Fault condition: halfword access with addr[0]=1, word access with addr[1:0]≠0, or illegal funct3.
  - No request is issued and no stall occurs.
  - Next edge: o_insn←BUBBLE_INSN, o_mem_fault←1. It is 0 on every other edge.
- States: IDLE, WAIT_RESP.
- IDLE, non-memory instruction:
  - No request; o_stall = 0.
  - Edge: o_insn←i_insn, o_ALU_O←i_ALU_O, o_mem_data←0. Latency is 1 edge, the same as a plain latch.
- IDLE, legal memory op:
  - dmem_req_valid = 1 combinationally.
  - Store: o_stall = !dmem_req_ready. On an edge with ready=1, the store completes (o_insn/o_ALU_O captured) and state stays IDLE.
  - Load: o_stall = 1. On an edge with ready=1, go to WAIT_RESP.
  - Edges with ready=0: o_insn←BUBBLE_INSN. Request fields must stay stable; upstream is stalled, so they are stable by construction.
- WAIT_RESP:
  - dmem_req_valid = 0; o_stall = !dmem_resp_valid.
  - On an edge with resp_valid=1: o_insn←i_insn, o_ALU_O←i_ALU_O, o_mem_data←format(rdata), go to IDLE.
  - Otherwise o_insn←BUBBLE_INSN.
- Handshake limits: a response in the same cycle as its request is not supported. At most one access is outstanding.
- Store formatting:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Load formatting: select the byte lane by addr[1:0] or the half lane by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Decomposition:
- Shared package `rv_pkg`:
  - opcode constants (OP_LOAD, OP_STORE)
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - BUBBLE_INSN default
  - mem_state_t enum {IDLE, WAIT_RESP}
- One combinational sub-module, `ls_align`: takes funct3, addr[1:0], rs2 and rdata; produces be, wdata, formatted load data and fault. The FSM and the M/W registers stay in mem_stage.

Test Plan:
- ADD passing through, no memory traffic → o_insn = that insn one falling edge later; o_stall never 1; dmem_req_valid never 1.
- SB with rs2=0x000000AB, addr=0x1003, ready held low 2 cycles then high → stall 1 for 2 cycles; be=4'b1000, wdata=0xABABABAB; two bubbles, then o_insn = SB.
- LB at addr=0x2002, rdata=0x12F03456, resp 3 cycles after accept → o_mem_data=0xFFFFFFF0; stall released on the resp edge. LBU of the same → 0x000000F0.
- LH at addr=0x2002 with rdata=0x80010000 → o_mem_data=0xFFFF8001. LW at 0x2001 → no request, o_mem_fault pulses 1, o_insn=0.
- Reset driven low while in WAIT_RESP, then resp_valid arrives after reset release → state IDLE; response ignored; all outputs 0; no stall.
- Back-to-back LW, SW, LW with ready always 1 and resp one cycle after accept → three completions in order with the correct data and no dropped or duplicated insn.
